// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared IFU definitions for the thread scheduler: thread-FSM state encodings,
// scheduler controller states and a small one-hot helper.
package sparc_ifu_thrsched_pkg;

  // Thread-FSM state encodings as presented by the per-thread FSMs
  localparam logic [4:0] THR_RDY      = 5'b11001;
  localparam logic [4:0] THR_RUN      = 5'b00101;
  localparam logic [4:0] THR_SPEC_RUN = 5'b00111;
  localparam logic [4:0] THR_SPEC_RDY = 5'b10011;

  // Scheduler controller states
  typedef enum logic {
    SCH_IDLE = 1'b0,
    SCH_RUN  = 1'b1
  } sch_state_e;

  // Convert a one-hot (or zero) 4-bit grant to a thread id
  function automatic logic [1:0] onehot_to_id(input logic [3:0] oh);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) id = 2'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/sparc_ifu_thrsched_rrarb.sv
// 4-way round-robin arbiter: the search starts at ptr and walks upward,
// wrapping 3->0; the first requester found wins.
module sparc_ifu_rrarb (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);

  logic [1:0] w_idx;

  // Walk from the farthest candidate back to ptr so the nearest requester wins
  always_comb begin
    gnt   = 4'b0000;
    w_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = ptr + 2'(k);
      if (req[w_idx]) gnt = 4'b0001 << w_idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// IFU thread scheduler: picks a ready thread round-robin, switches it in,
// and switches the current thread out on a fetch-control request when
// another thread is eligible. All outputs are registered pulses/state.
// Optional feature macro: IFU_SPEC_PICK_EN -- SPEC_RDY threads become
// eligible as a lower-priority class behind RDY threads.
// Handshake: there is no back-pressure; schedule/switch_out are one-cycle
// pulses that the thread FSMs must accept in the cycle they are high.
// Scan chain order: si -> state -> ptr[0..1] -> cur_thr[0..1] -> cur_vld
// -> schedule[0..3] -> switch_out[0..3] -> so.
module sparc_ifu_thrsched
  import sparc_ifu_thrsched_pkg::*;
(
  input  logic       clk,
  input  logic       arst_l,
  input  logic       se,
  input  logic       si,
  output logic       so,
  input  logic [4:0] thr_state_t0,
  input  logic [4:0] thr_state_t1,
  input  logic [4:0] thr_state_t2,
  input  logic [4:0] thr_state_t3,
  input  logic       sw_req,
  input  logic       hold,
  output logic [3:0] schedule,
  output logic [3:0] switch_out,
  output logic [1:0] cur_thr,
  output logic       cur_vld,
  output logic       dbg_state,
  output logic [1:0] dbg_ptr
);

  sch_state_e r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_cur_thr;
  logic       r_cur_vld;
  logic [3:0] r_schedule;
  logic [3:0] r_switch_out;

  logic [4:0] w_st [4];
  logic [3:0] w_rdy;
  logic [3:0] w_excl;
  logic [3:0] w_gnt_rdy;
  logic       w_any_rdy;
  logic [3:0] w_gnt;
  logic       w_any;
  logic [1:0] w_win;
  logic [4:0] w_cur_st;
  logic       w_lost;

  assign w_st[0] = thr_state_t0;
  assign w_st[1] = thr_state_t1;
  assign w_st[2] = thr_state_t2;
  assign w_st[3] = thr_state_t3;

  // Eligibility decode; the running thread is never a switch-in candidate
  always_comb begin
    w_rdy = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_rdy[i] = (w_st[i] == THR_RDY);
    end
  end

  assign w_excl = (r_state == SCH_RUN) ? (4'b0001 << r_cur_thr) : 4'b0000;

  sparc_ifu_rrarb u_arb_rdy (
    .req (w_rdy & ~w_excl),
    .ptr (r_ptr),
    .gnt (w_gnt_rdy),
    .any (w_any_rdy)
  );

`ifdef IFU_SPEC_PICK_EN
  logic [3:0] w_spec;
  logic [3:0] w_gnt_spec;
  logic       w_any_spec;

  // Speculatively-ready threads form a second, lower-priority class
  always_comb begin
    w_spec = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_spec[i] = (w_st[i] == THR_SPEC_RDY);
    end
  end

  sparc_ifu_rrarb u_arb_spec (
    .req (w_spec & ~w_excl),
    .ptr (r_ptr),
    .gnt (w_gnt_spec),
    .any (w_any_spec)
  );

  assign w_gnt = w_any_rdy ? w_gnt_rdy : w_gnt_spec;
  assign w_any = w_any_rdy | w_any_spec;
`else
  assign w_gnt = w_gnt_rdy;
  assign w_any = w_any_rdy;
`endif

  assign w_win    = onehot_to_id(w_gnt);
  assign w_cur_st = w_st[r_cur_thr];

  // The freshly switched-in thread still shows RDY while schedule is high,
  // so the lost check is masked in that cycle.
  assign w_lost = (r_state == SCH_RUN) && !(|r_schedule) &&
                  (w_cur_st != THR_RUN) && (w_cur_st != THR_SPEC_RUN);

  // Controller FSM with registered pulses; scan shift takes priority over function
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_state      <= SCH_IDLE;
      r_ptr        <= 2'd0;
      r_cur_thr    <= 2'd0;
      r_cur_vld    <= 1'b0;
      r_schedule   <= 4'b0000;
      r_switch_out <= 4'b0000;
    end else if (se) begin
      r_state      <= sch_state_e'(si);
      r_ptr        <= {r_ptr[0], logic'(r_state)};
      r_cur_thr    <= {r_cur_thr[0], r_ptr[1]};
      r_cur_vld    <= r_cur_thr[1];
      r_schedule   <= {r_schedule[2:0], r_cur_vld};
      r_switch_out <= {r_switch_out[2:0], r_schedule[3]};
    end else begin
      r_schedule   <= 4'b0000;
      r_switch_out <= 4'b0000;
      case (r_state)
        SCH_IDLE: begin
          if (!hold && w_any) begin
            r_schedule <= w_gnt;
            r_cur_thr  <= w_win;
            r_cur_vld  <= 1'b1;
            r_ptr      <= w_win + 2'd1;
            r_state    <= SCH_RUN;
          end
        end
        SCH_RUN: begin
          if (w_lost) begin
            r_cur_vld <= 1'b0;
            r_state   <= SCH_IDLE;
          end else if (sw_req && !hold && w_any) begin
            r_switch_out <= 4'b0001 << r_cur_thr;
            r_schedule   <= w_gnt;
            r_cur_thr    <= w_win;
            r_ptr        <= w_win + 2'd1;
          end
        end
        default: r_state <= SCH_IDLE;
      endcase
    end
  end

  assign schedule   = r_schedule;
  assign switch_out = r_switch_out;
  assign cur_thr    = r_cur_thr;
  assign cur_vld    = r_cur_vld;
  assign so         = r_switch_out[3];
  assign dbg_state  = r_state;
  assign dbg_ptr    = r_ptr;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Testbench for sparc_ifu_thrsched: directed scenarios plus random thread
// states, checked by a scoreboard fed from a behavioural scheduler model.
module tb_sparc_ifu_thrsched;

  localparam logic [4:0] ST_RDY      = 5'b11001;
  localparam logic [4:0] ST_RUN      = 5'b00101;
  localparam logic [4:0] ST_SPEC_RUN = 5'b00111;
  localparam logic [4:0] ST_SPEC_RDY = 5'b10011;
  localparam logic [4:0] ST_IDLE     = 5'b00000;
  localparam logic [4:0] ST_WAIT     = 5'b00010;
`ifdef IFU_SPEC_PICK_EN
  localparam int NCLS = 2;
`else
  localparam int NCLS = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       arst_l;
  logic       se;
  logic       si;
  logic       so;
  logic [4:0] thr_state_t0, thr_state_t1, thr_state_t2, thr_state_t3;
  logic       sw_req;
  logic       hold;
  logic [3:0] schedule;
  logic [3:0] switch_out;
  logic [1:0] cur_thr;
  logic       cur_vld;
  logic       dbg_state;
  logic [1:0] dbg_ptr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sparc_ifu_thrsched dut (
    .clk          (clk),
    .arst_l       (arst_l),
    .se           (se),
    .si           (si),
    .so           (so),
    .thr_state_t0 (thr_state_t0),
    .thr_state_t1 (thr_state_t1),
    .thr_state_t2 (thr_state_t2),
    .thr_state_t3 (thr_state_t3),
    .sw_req       (sw_req),
    .hold         (hold),
    .schedule     (schedule),
    .switch_out   (switch_out),
    .cur_thr      (cur_thr),
    .cur_vld      (cur_vld),
    .dbg_state    (dbg_state),
    .dbg_ptr      (dbg_ptr)
  );

  // ---------------- scoreboard state ----------------
  // expected = {schedule, switch_out, cur_thr, cur_vld, ptr, running}
  logic [13:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  logic [4:0] st [4];
  bit  m_run, m_vld, m_sched_prev;
  int  m_cur, m_ptr;

  function automatic int pick(input int excl);
    int w;
    logic [4:0] cls_st;
    w = -1;
    for (int c = 0; c < NCLS; c++) begin
      cls_st = (c == 0) ? ST_RDY : ST_SPEC_RDY;
      for (int k = 0; k < 4; k++) begin
        int t;
        t = (m_ptr + k) % 4;
        if (w < 0 && t != excl && st[t] == cls_st) w = t;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_run = 0; m_vld = 0; m_sched_prev = 0; m_cur = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    logic [3:0] s_exp, o_exp;
    int  w;
    bit  lost;
    s_exp = 4'b0000;
    o_exp = 4'b0000;
    if (!m_run) begin
      w = pick(-1);
      if (!hold && w >= 0) begin
        s_exp = 4'(1 << w);
        m_cur = w; m_vld = 1; m_ptr = (w + 1) % 4; m_run = 1;
      end
    end else begin
      lost = !m_sched_prev && st[m_cur] != ST_RUN && st[m_cur] != ST_SPEC_RUN;
      if (lost) begin
        m_vld = 0; m_run = 0;
      end else if (sw_req && !hold) begin
        w = pick(m_cur);
        if (w >= 0) begin
          o_exp = 4'(1 << m_cur);
          s_exp = 4'(1 << w);
          m_cur = w; m_ptr = (w + 1) % 4;
        end
      end
    end
    m_sched_prev = (s_exp != 4'b0000);
    exp_q.push_back({s_exp, o_exp, 2'(m_cur), m_vld, 2'(m_ptr), m_run});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [4:0] d, input logic sw, input logic hd);
    @(negedge clk);
    arst_l = 1'b1;
    thr_state_t0 = a; thr_state_t1 = b; thr_state_t2 = c; thr_state_t3 = d;
    st[0] = a; st[1] = b; st[2] = c; st[3] = d;
    sw_req = sw;
    hold   = hd;
    model_step();
  endtask

  task automatic do_reset();
    logic [13:0] got;
    @(negedge clk);
    arst_l = 1'b0;
    #1;
    got = {schedule, switch_out, cur_thr, cur_vld, dbg_ptr, dbg_state};
    total++;
    if (got !== 14'd0) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b", got, 14'd0);
    end
    model_reset();
    exp_q.push_back(14'd0);
  endtask

  function automatic logic [4:0] rand_other();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30) return ST_RDY;
    if (r < 45) return ST_SPEC_RDY;
    if (r < 75) return ST_IDLE;
    return ST_WAIT;
  endfunction

  task automatic rand_cycle();
    logic [4:0] s [4];
    for (int i = 0; i < 4; i++) s[i] = rand_other();
    if (m_run) begin
      int r;
      r = $urandom_range(0, 99);
      s[m_cur] = (r < 70) ? ST_RUN : (r < 88) ? ST_SPEC_RUN : ST_WAIT;
    end
    drive(s[0], s[1], s[2], s[3], ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 15));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [13:0] got, exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {schedule, switch_out, cur_thr, cur_vld, dbg_ptr, dbg_state};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL scoreboard cyc=%0d got sch=%b swo=%b cur=%0d vld=%b ptr=%0d st=%b exp sch=%b swo=%b cur=%0d vld=%b ptr=%0d st=%b",
                   cyc, got[13:10], got[9:6], got[5:4], got[3], got[2:1], got[0],
                   exp[13:10], exp[9:6], exp[5:4], exp[3], exp[2:1], exp[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    arst_l = 1'b0; se = 1'b0; si = 1'b0;
    sw_req = 1'b0; hold = 1'b0;
    thr_state_t0 = ST_IDLE; thr_state_t1 = ST_IDLE;
    thr_state_t2 = ST_IDLE; thr_state_t3 = ST_IDLE;
    for (int i = 0; i < 4; i++) st[i] = ST_IDLE;
    model_reset();

    do_reset();
    // first pick after reset: t2 alone ready
    drive(ST_IDLE, ST_IDLE, ST_RDY,  ST_IDLE, 1'b0, 1'b0);
    // switch-out of t2 with t0/t3 ready, pointer at 3 -> t3
    drive(ST_RDY,  ST_IDLE, ST_RUN,  ST_RDY,  1'b1, 1'b0);
    drive(ST_RDY,  ST_IDLE, ST_IDLE, ST_RUN,  1'b0, 1'b0);
    // current goes to WAIT during a switch request: lost wins
    drive(ST_RDY,  ST_IDLE, ST_IDLE, ST_WAIT, 1'b1, 1'b0);
    drive(ST_RDY,  ST_IDLE, ST_IDLE, ST_IDLE, 1'b0, 1'b0);
    // switch request with nobody else eligible is ignored
    drive(ST_RUN,  ST_IDLE, ST_IDLE, ST_IDLE, 1'b1, 1'b0);
    drive(ST_RUN,  ST_WAIT, ST_IDLE, ST_IDLE, 1'b1, 1'b0);
    // hold freezes picks
    do_reset();
    repeat (3) drive(ST_RDY, ST_IDLE, ST_IDLE, ST_IDLE, 1'b0, 1'b1);
    drive(ST_RDY, ST_IDLE, ST_IDLE, ST_IDLE, 1'b0, 1'b0);
    // speculative-ready only thread
    do_reset();
    drive(ST_IDLE, ST_SPEC_RDY, ST_IDLE, ST_IDLE, 1'b0, 1'b0);
    drive(ST_IDLE, ST_SPEC_RDY, ST_IDLE, ST_RDY,  1'b0, 1'b0);
    drive(ST_IDLE, ST_SPEC_RDY, ST_IDLE, ST_RUN,  1'b1, 1'b0);

    // randomized traffic with occasional mid-run resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else rand_cycle();
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
